button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 250000, consecutive stable cycles required to accept a level change (10 ms @ 25 MHz).
REQ-002 SHALL have parameter DB_BITS, default 18, debounce counter width.
REQ-003 SHALL have parameter REPEAT_DELAY, default 12500000, cycles from press step to first repeat step (0.5 s).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 2500000, cycles between subsequent repeat steps (0.1 s).
REQ-005 SHALL have parameter RPT_BITS, default 24, repeat timer width.
REQ-006 SHALL have parameter REPEAT_EN, default 1, 1 = auto-repeat enabled, 0 = one step per press.
REQ-007 SHALL have port clkin, input, 1, 25 MHz system clock; all flops on its rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port btn_in, input, 1, raw asynchronous push-button, active high.
REQ-010 SHALL have port btn_level, output, 1, debounced button level.
REQ-011 SHALL have port step, output, 1, one-cycle pulse on each accepted press or repeat; drives the counter's advance enable.
REQ-012 SHALL have port release_pulse, output, 1, one-cycle pulse on debounced release.

Function
REQ-013 SHALL pass btn_in through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-014 Debounce counter SHALL clear to 0 on any cycle where sync2 == btn_level.
REQ-015 While sync2 != btn_level, the counter SHALL increment by 1 per cycle; on the edge where it equals STABLE_CYCLES-1 with mismatch still present, btn_level SHALL take sync2 and the counter SHALL clear.
REQ-016 Latency: a btn_in change held stable SHALL appear on btn_level at the (STABLE_CYCLES+2)th rising edge after the change; any glitch shorter than STABLE_CYCLES synchronized cycles SHALL NOT change btn_level.
REQ-017 Counter SHALL never exceed STABLE_CYCLES-1 (no wrap); DB_BITS SHALL hold STABLE_CYCLES-1.
REQ-018 FSM states SHALL be IDLE, DELAY and REPEAT, with a repeat timer of RPT_BITS.
REQ-019 IDLE: on btn_level rising, SHALL assert step next cycle, clear the timer and go to DELAY.
REQ-020 DELAY: timer SHALL increment each cycle; at REPEAT_DELAY-1 with REPEAT_EN=1, SHALL assert step next cycle, clear the timer and go to REPEAT; with REPEAT_EN=0, SHALL hold the timer at REPEAT_DELAY-1 and remain in DELAY.
REQ-021 REPEAT: timer SHALL increment; at REPEAT_PERIOD-1 SHALL assert step next cycle and clear the timer.
REQ-022 In any non-IDLE state, btn_level falling SHALL assert release_pulse next cycle, clear the timer and go to IDLE; release SHALL take priority over a coincident repeat step (no step that cycle).
REQ-023 step and release_pulse SHALL be registered, high exactly one cycle per event, never simultaneously.
REQ-024 Unreachable state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-025 rst high SHALL immediately clear sync1, sync2, btn_level, debounce counter, repeat timer, step and release_pulse to 0 and force IDLE, independent of clkin.
REQ-026 Reset mid-press SHALL abort without a release_pulse; after deassertion with btn_in still high, a fresh press SHALL be detected per REQ-016/REQ-019.

Verification (bench parameters: STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 btn_in 0->1 held -> btn_level 1 at 6th edge; step high for the one cycle after the 7th edge; second step 10 cycles later, then every 3 cycles.
REQ-028 btn_in pulses high 3 synchronized cycles, then low -> btn_level, step, release_pulse stay 0.
REQ-029 Press held 20 cycles past first step, then released -> btn_level 0 six edges after release; one release_pulse; no further step.
REQ-030 Release timed so btn_level falls on the cycle the REPEAT timer reaches 2 -> release_pulse only, no step.
REQ-031 REPEAT_EN=0, press held 100 cycles -> exactly one step.
REQ-032 rst asserted between clock edges mid-REPEAT -> all outputs 0 immediately; btn_in held high -> new step 7 edges after deassertion.

Source files
------------

// File: rtl/button_debounce.sv
// Push-button front end: synchronizer, debounce filter and press/auto-repeat
// sequencer producing one-cycle step and release pulses.
module button_debounce #(
  parameter int STABLE_CYCLES = 250000,
  parameter int DB_BITS       = 18,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter int RPT_BITS      = 24,
  parameter int REPEAT_EN     = 1
) (
  input  logic clkin,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic step,
  output logic release_pulse
);

  // state  | meaning
  // IDLE   | button released, waiting for a debounced press
  // DELAY  | pressed, timing the initial auto-repeat delay
  // REPEAT | pressed, stepping every REPEAT_PERIOD cycles
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [DB_BITS-1:0]  DB_TC     = DB_BITS'(STABLE_CYCLES - 1);
  localparam logic [RPT_BITS-1:0] DELAY_TC  = RPT_BITS'(REPEAT_DELAY - 1);
  localparam logic [RPT_BITS-1:0] PERIOD_TC = RPT_BITS'(REPEAT_PERIOD - 1);

  state_t              state;
  logic                sync1;
  logic                sync2;
  logic                level_q;
  logic [DB_BITS-1:0]  db_cnt;
  logic [RPT_BITS-1:0] rpt_tmr;
  logic                level_rise;
  logic                level_fall;

  assign level_rise = btn_level & ~level_q;
  assign level_fall = ~btn_level & level_q;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      btn_level <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      if (sync2 == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_TC) begin
        btn_level <= sync2;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DB_BITS'(1);
      end
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      level_q       <= 1'b0;
      rpt_tmr       <= '0;
      step          <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      level_q       <= btn_level;
      step          <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (level_rise) begin
            step    <= 1'b1;
            rpt_tmr <= '0;
            state   <= DELAY;
          end
        end
        DELAY: begin
          if (level_fall) begin
            release_pulse <= 1'b1;
            rpt_tmr       <= '0;
            state         <= IDLE;
          end else if (rpt_tmr == DELAY_TC) begin
            // Without auto-repeat the timer parks at terminal count until release.
            if (REPEAT_EN != 0) begin
              step    <= 1'b1;
              rpt_tmr <= '0;
              state   <= REPEAT;
            end
          end else begin
            rpt_tmr <= rpt_tmr + RPT_BITS'(1);
          end
        end
        REPEAT: begin
          if (level_fall) begin
            release_pulse <= 1'b1;
            rpt_tmr       <= '0;
            state         <= IDLE;
          end else if (rpt_tmr == PERIOD_TC) begin
            step    <= 1'b1;
            rpt_tmr <= '0;
          end else begin
            rpt_tmr <= rpt_tmr + RPT_BITS'(1);
          end
        end
        default: begin
          rpt_tmr <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: two instances (auto-repeat on/off) driven by the
// same button, checked every cycle against a press-age reference model.
module tb_button_debounce;

  localparam int SC = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clkin = 1'b0;
  logic rst;
  logic btn_in;
  logic lvl1, step1, rel1;
  logic lvl0, step0, rel0;

  int n_checks = 0;
  int n_errors = 0;

  button_debounce #(.STABLE_CYCLES(SC), .DB_BITS(3), .REPEAT_DELAY(RD),
                    .REPEAT_PERIOD(RP), .RPT_BITS(8), .REPEAT_EN(1)) u_dut1 (
    .clkin(clkin), .rst(rst), .btn_in(btn_in),
    .btn_level(lvl1), .step(step1), .release_pulse(rel1));

  button_debounce #(.STABLE_CYCLES(SC), .DB_BITS(3), .REPEAT_DELAY(RD),
                    .REPEAT_PERIOD(RP), .RPT_BITS(8), .REPEAT_EN(0)) u_dut0 (
    .clkin(clkin), .rst(rst), .btn_in(btn_in),
    .btn_level(lvl0), .step(step0), .release_pulse(rel0));

  always #5 clkin = ~clkin;

  // Reference model: pipeline delay, mismatch run length, and press age.
  bit m_s1, m_s2, m_lvl, m_lvl_d, pressed;
  bit e_step1, e_step0, e_rel;
  int mism, age;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_lvl_d = 0; pressed = 0;
    e_step1 = 0; e_step0 = 0; e_rel = 0; mism = 0; age = 0;
  endtask

  task automatic model_edge(input bit b);
    bit rise, fall;
    rise = m_lvl && !m_lvl_d;
    fall = !m_lvl && m_lvl_d;
    e_step1 = 0; e_step0 = 0; e_rel = 0;
    if (rise) begin
      pressed = 1; age = 0; e_step1 = 1; e_step0 = 1;
    end else if (pressed && fall) begin
      pressed = 0; e_rel = 1;
    end else if (pressed) begin
      age++;
      if (age == RD || (age > RD && (age - RD) % RP == 0)) e_step1 = 1;
    end
    m_lvl_d = m_lvl;
    if (m_s2 != m_lvl) begin
      mism++;
      if (mism == SC) begin
        m_lvl = m_s2;
        mism  = 0;
      end
    end else begin
      mism = 0;
    end
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("btn_level_rpt", int'(lvl1), int'(m_lvl));
    chk("btn_level_norpt", int'(lvl0), int'(m_lvl));
    chk("step_rpt", int'(step1), int'(e_step1));
    chk("step_norpt", int'(step0), int'(e_step0));
    chk("release_rpt", int'(rel1), int'(e_rel));
    chk("release_norpt", int'(rel0), int'(e_rel));
  endtask

  task automatic apply(input bit b);
    btn_in = b;
    model_edge(b);
    @(posedge clkin);
    #1;
    compare_all();
  endtask

  typedef struct {
    bit btn;
    int len;
    bit lvl;
    int steps1;
    int steps0;
    int rels;
  } vec_t;

  vec_t vecs[9];
  int   s1_cnt, s0_cnt, r1_cnt, r0_cnt, found;

  initial begin
    vecs[0] = '{0, 5,   0, 0,  0, 0};
    vecs[1] = '{1, 3,   0, 0,  0, 0};
    vecs[2] = '{0, 8,   0, 0,  0, 0};
    vecs[3] = '{1, 27,  1, 5,  1, 0};
    vecs[4] = '{0, 12,  0, 2,  0, 1};
    vecs[5] = '{1, 28,  1, 5,  1, 0};
    vecs[6] = '{0, 12,  0, 2,  0, 1};
    vecs[7] = '{1, 100, 1, 29, 1, 0};
    vecs[8] = '{0, 12,  0, 2,  0, 1};

    rst = 1'b1;
    btn_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clkin);
    #1;
    compare_all();
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      s1_cnt = 0; s0_cnt = 0; r1_cnt = 0; r0_cnt = 0;
      for (int c = 0; c < vecs[v].len; c++) begin
        apply(vecs[v].btn);
        s1_cnt += int'(step1);
        s0_cnt += int'(step0);
        r1_cnt += int'(rel1);
        r0_cnt += int'(rel0);
      end
      chk($sformatf("vec%0d_level", v), int'(lvl1), int'(vecs[v].lvl));
      chk($sformatf("vec%0d_steps_rpt", v), s1_cnt, vecs[v].steps1);
      chk($sformatf("vec%0d_steps_norpt", v), s0_cnt, vecs[v].steps0);
      chk($sformatf("vec%0d_rel_rpt", v), r1_cnt, vecs[v].rels);
      chk($sformatf("vec%0d_rel_norpt", v), r0_cnt, vecs[v].rels);
    end

    for (int seg = 0; seg < 60; seg++) begin
      bit b;
      int len;
      b   = 1'($urandom_range(0, 1));
      len = (seg % 5 == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 8));
      for (int c = 0; c < len; c++) apply(b);
    end

    // Reset mid-REPEAT, asserted between edges right after a repeat step.
    for (int c = 0; c < 20; c++) apply(1'b0);
    for (int c = 0; c < 20; c++) apply(1'b1);
    chk("pre_reset_step", int'(step1), 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1;
    rst = 1'b0;
    found = 0;
    for (int c = 1; c <= 20; c++) begin
      apply(1'b1);
      if (step1 && found == 0) found = c;
    end
    chk("post_reset_step_edge", found, 7);
    for (int c = 0; c < 12; c++) apply(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
